lsm_mem_unit: RTL and testbench
===============================

// Module: lsm_mem_unit
// PURPOSE
//  Memory stage for LDM/STM block transfers, directly downstream of the LDM sequencer.
//  Per sequenced transfer it forms the word address from the latched base and offset,
//  runs a req/ack bus cycle, writes load data to the register file and sources store data.
//  After the last transfer it performs base-register writeback.
//  Backpressures the sequencer through o_stall, which drives the sequencer's en low.
// PARAMETERS
//  AW   32  bus address width (word aligned; addr[1:0] always 2'b00)
//  DW   32  data width
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  i_start      in   1   first cycle of an LDM/STM; latches the fields below
//  i_base       in   32  base register value Rn
//  i_base_reg   in   4   Rn index
//  i_u          in   1   1=increment, 0=decrement
//  i_l          in   1   1=load, 0=store
//  i_w          in   1   base writeback enable
//  i_reglist    in   16  register list (popcount = n)
//  i_xfer_vld   in   1   sequencer transfer valid
//  i_xfer_off   in   32  byte offset from sequencer (multiple of 4; before-modes pre-biased)
//  i_xfer_reg   in   4   register for this transfer
//  i_st_data    in   DW  register-file read data for i_xfer_reg (stores)
//  o_mem_req    out  1   bus request
//  o_mem_we     out  1   1=write
//  o_mem_addr   out  AW  word address
//  o_mem_wdata  out  DW  store data
//  i_mem_ack    in   1   bus acknowledge; completes the request in the same cycle
//  i_mem_rdata  in   DW  load data, valid with i_mem_ack
//  o_rf_we      out  1   register-file write strobe
//  o_rf_waddr   out  4   register-file write index
//  o_rf_wdata   out  DW  register-file write data
//  o_stall      out  1   hold upstream sequencer
//  o_busy       out  1   transfer group in progress
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; latched base, n and done-count cleared.
//  FSM states IDLE, XFER, BUS, WB:
//   IDLE: on i_start, latch base, Rn, U, L, W and n=popcount(i_reglist); clear done.
//         If n==0, stay in IDLE with no bus cycle and no writeback. Otherwise go to XFER.
//   XFER: on i_xfer_vld, register addr, reg and wdata, assert o_mem_req and go to BUS.
//         Address: U ? base+off : base-off, modulo 2^32, [1:0] forced to 0.
//   BUS:  o_mem_req, o_mem_we (=~L), o_mem_addr and o_mem_wdata stay stable until i_mem_ack.
//         On ack, done++. For loads, o_rf_we pulses in the next cycle with the registered
//         i_mem_rdata and reg. Next state is XFER if done<n, otherwise WB if W, else IDLE.
//   WB:   one cycle of o_rf_we with waddr=Rn and wdata = U ? base+4n : base-4n.
//         Writeback is suppressed when L=1 and Rn is in the reglist (the loaded value wins).
//         Then go to IDLE.
//  o_stall = (state==BUS & ~i_mem_ack) | state==WB. An ack in BUS with a new i_xfer_vld
//   in the same cycle does not stall: that transfer is latched and BUS re-entered (back-to-back).
//  Loaded-data rf write and the WB write never occur in the same cycle; WB follows the
//   load write by one cycle.
//  i_start outside IDLE is ignored. o_busy = state!=IDLE.
//  Reset mid-transfer: request dropped immediately (async); a pending rf write is lost.
// TESTING
//  LDMIA r0!,{r1,r2,r3}, base=0x1000, ack=1 every cycle -> addrs 0x1000/04/08; r1..r3 written; r0=0x100C.
//  STMDB sp!,{r4,lr}, sp=0x2000, sequencer offs 4,8 -> writes 0x1FFC(lr) and 0x1FF8(r4); sp=0x1FF8.
//  LDMIA r0,{r0,r1} with W=1 -> r0 gets loaded data; no base writeback cycle.
//  3-cycle ack latency per beat -> o_stall high 3 cycles per beat; addr/we/wdata stable throughout.
//  Base 0xFFFFFFFC, IB, {r0} -> addr 0x00000000 (wrap); writeback value 0x00000000.
//  rst_n low while o_mem_req=1 -> req, rf_we and stall drop at once; FSM=IDLE after release.

Source files
------------

// File: rtl/lsm_mem_unit.sv
// Memory stage for LDM/STM block transfers: turns sequencer beats into req/ack bus
// cycles, writes load data to the register file and performs base writeback.
module lsm_mem_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [31:0]   i_base,
    input  logic [3:0]    i_base_reg,
    input  logic          i_u,
    input  logic          i_l,
    input  logic          i_w,
    input  logic [15:0]   i_reglist,
    input  logic          i_xfer_vld,
    input  logic [31:0]   i_xfer_off,
    input  logic [3:0]    i_xfer_reg,
    input  logic [DW-1:0] i_st_data,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_rf_we,
    output logic [3:0]    o_rf_waddr,
    output logic [DW-1:0] o_rf_wdata,
    output logic          o_stall,
    output logic          o_busy
);

    typedef enum logic [1:0] {IDLE, XFER, BUS, WB} state_t;

    state_t        state_reg, state_next;

    logic [31:0]   base_reg;
    logic [3:0]    rn_reg;
    logic          u_reg, l_reg, w_reg, rn_in_list_reg;
    logic [4:0]    n_reg, done_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [3:0]    xreg_reg;
    logic          req_reg, we_reg;
    logic          rf_we_reg;
    logic [3:0]    rf_waddr_reg;
    logic [DW-1:0] rf_wdata_reg;

    logic [4:0]    pop_cnt;
    logic [4:0]    done_inc;
    logic          more_beats;
    logic          wb_needed;
    logic [31:0]   addr_calc;
    logic [31:0]   wb_value;
    logic          start_take, xfer_take, ack_take, wb_active;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            pop_cnt = pop_cnt + {4'd0, i_reglist[i]};
        end
    end

    assign done_inc   = done_reg + 5'd1;
    assign more_beats = (done_inc < n_reg);
    // A load that includes Rn must keep the loaded value, so the base update is dropped.
    assign wb_needed  = w_reg & ~(l_reg & rn_in_list_reg);
    assign addr_calc  = u_reg ? (base_reg + i_xfer_off) : (base_reg - i_xfer_off);
    assign wb_value   = u_reg ? (base_reg + {25'd0, n_reg, 2'b00})
                              : (base_reg - {25'd0, n_reg, 2'b00});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_start && (pop_cnt != 5'd0)) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (i_xfer_vld) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                if (i_mem_ack) begin
                    if (more_beats) begin
                        state_next = i_xfer_vld ? BUS : XFER;
                    end else begin
                        state_next = wb_needed ? WB : IDLE;
                    end
                end
            end
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        start_take = (state_reg == IDLE) & i_start;
        ack_take   = (state_reg == BUS) & i_mem_ack;
        xfer_take  = ((state_reg == XFER) & i_xfer_vld) |
                     (ack_take & more_beats & i_xfer_vld);
        wb_active  = (state_reg == WB);
        o_stall    = ((state_reg == BUS) & ~i_mem_ack) | (state_reg == WB);
        o_busy     = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg       <= '0;
            rn_reg         <= '0;
            u_reg          <= 1'b0;
            l_reg          <= 1'b0;
            w_reg          <= 1'b0;
            rn_in_list_reg <= 1'b0;
            n_reg          <= '0;
            done_reg       <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            xreg_reg       <= '0;
            req_reg        <= 1'b0;
            we_reg         <= 1'b0;
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= '0;
            rf_wdata_reg   <= '0;
        end else begin
            req_reg <= (state_next == BUS);
            if (start_take) begin
                base_reg       <= i_base;
                rn_reg         <= i_base_reg;
                u_reg          <= i_u;
                l_reg          <= i_l;
                w_reg          <= i_w;
                n_reg          <= pop_cnt;
                rn_in_list_reg <= i_reglist[i_base_reg];
                done_reg       <= '0;
            end
            if (xfer_take) begin
                addr_reg  <= {addr_calc[AW-1:2], 2'b00};
                we_reg    <= ~l_reg;
                wdata_reg <= i_st_data;
                xreg_reg  <= i_xfer_reg;
            end
            if (ack_take) begin
                done_reg <= done_inc;
            end
            // Load write lands the cycle after ack; the WB write one cycle after that.
            rf_we_reg <= (ack_take & l_reg) | wb_active;
            if (wb_active) begin
                rf_waddr_reg <= rn_reg;
                rf_wdata_reg <= wb_value;
            end else if (ack_take) begin
                rf_waddr_reg <= xreg_reg;
                rf_wdata_reg <= i_mem_rdata;
            end
        end
    end

    assign o_mem_req   = req_reg;
    assign o_mem_we    = we_reg;
    assign o_mem_addr  = addr_reg;
    assign o_mem_wdata = wdata_reg;
    assign o_rf_we     = rf_we_reg;
    assign o_rf_waddr  = rf_waddr_reg;
    assign o_rf_wdata  = rf_wdata_reg;

endmodule

// File: tb/tb_lsm_mem_unit.sv
// Scoreboard bench for lsm_mem_unit: directed LDM/STM groups, a latency-programmable
// bus responder, and a monitor that checks every bus beat and register-file write.
module tb_lsm_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_base = '0;
    logic [3:0]  i_base_reg = '0;
    logic        i_u = 1'b0, i_l = 1'b0, i_w = 1'b0;
    logic [15:0] i_reglist = '0;
    logic        i_xfer_vld = 1'b0;
    logic [31:0] i_xfer_off = '0;
    logic [3:0]  i_xfer_reg = '0;
    logic [31:0] i_st_data = '0;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_rf_we;
    logic [3:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_stall, o_busy;

    lsm_mem_unit #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base(i_base),
        .i_base_reg(i_base_reg), .i_u(i_u), .i_l(i_l), .i_w(i_w),
        .i_reglist(i_reglist), .i_xfer_vld(i_xfer_vld), .i_xfer_off(i_xfer_off),
        .i_xfer_reg(i_xfer_reg), .i_st_data(i_st_data), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_rf_we(o_rf_we),
        .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata), .o_stall(o_stall),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] off; logic [3:0] rg; logic [31:0] sd; logic [31:0] ea;} ent_t;
    typedef struct {logic [31:0] addr; logic we; logic [31:0] wd; int lat;} bus_t;
    typedef struct {logic [3:0] a; logic [31:0] d;} rf_t;

    ent_t seq_q[$];
    bus_t bus_q[$];
    rf_t  rf_q[$];

    int total = 0;
    int bad = 0;
    int lat = 0;
    int wc = 0;
    int rd_cnt = 0;
    int exp_beat = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Bus responder: acks after 'lat' wait cycles, read data is a running beat count.
    always @(negedge clk) begin
        if (!rst_n) begin
            i_mem_ack = 1'b0;
            wc = 0;
        end else if (o_mem_req) begin
            if (wc >= lat) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = 32'hCAFE_0000 + 32'(rd_cnt);
                rd_cnt++;
                wc = 0;
            end else begin
                i_mem_ack = 1'b0;
                wc++;
            end
        end else begin
            i_mem_ack = 1'b0;
            wc = 0;
        end
    end

    // Monitor
    int          scnt = 0;
    bit          pend = 1'b0;
    logic [64:0] prev = '0;
    bus_t        eb;
    rf_t         er;

    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            scnt = 0;
            pend = 1'b0;
        end else begin
            if (o_mem_req) begin
                if (pend) chk("bus_stable", {o_mem_addr, o_mem_we, o_mem_wdata}, prev);
                if (o_stall) scnt++;
                if (i_mem_ack) begin
                    $display("bus beat addr=%08h we=%0d wdata=%08h wait=%0d",
                             o_mem_addr, o_mem_we, o_mem_wdata, scnt);
                    if (bus_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL bus_unexpected actual=%08h required=none", o_mem_addr);
                    end else begin
                        eb = bus_q.pop_front();
                        chk("bus_beat", {o_mem_addr, o_mem_we, o_mem_we ? o_mem_wdata : 32'h0},
                            {eb.addr, eb.we, eb.we ? eb.wd : 32'h0});
                        chk("stall_cycles", 128'(scnt), 128'(eb.lat));
                    end
                    scnt = 0;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    prev = {o_mem_addr, o_mem_we, o_mem_wdata};
                end
            end
            if (o_rf_we) begin
                $display("rf write r%0d=%08h", o_rf_waddr, o_rf_wdata);
                if (rf_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rf_unexpected actual=r%0d required=none", o_rf_waddr);
                end else begin
                    er = rf_q.pop_front();
                    chk("rf_write", {o_rf_waddr, o_rf_wdata}, {er.a, er.d});
                end
            end
        end
    end

    task automatic push_ent(input [31:0] off, input [3:0] rg, input [31:0] sd, input [31:0] ea);
        seq_q.push_back('{off, rg, sd, ea});
    endtask

    task automatic run_op(input string nm, input [31:0] base, input [3:0] rn, input bit u,
                          input bit l, input bit w, input [15:0] rl, input int lt,
                          input bit wb_exp, input [31:0] wb_val);
        int idx;
        int cyc;
        lat = lt;
        foreach (seq_q[k]) begin
            bus_q.push_back('{seq_q[k].ea, !l, seq_q[k].sd, lt});
            if (l) rf_q.push_back('{seq_q[k].rg, 32'hCAFE_0000 + 32'(exp_beat)});
            exp_beat++;
        end
        if (wb_exp) rf_q.push_back('{rn, wb_val});
        @(negedge clk); #1;
        i_start = 1'b1; i_base = base; i_base_reg = rn;
        i_u = u; i_l = l; i_w = w; i_reglist = rl;
        @(negedge clk); #1;
        i_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < seq_q.size() && cyc < 200) begin
            i_xfer_vld = 1'b1;
            i_xfer_off = seq_q[idx].off;
            i_xfer_reg = seq_q[idx].rg;
            i_st_data  = seq_q[idx].sd;
            if (!o_stall) idx++;
            @(negedge clk); #1;
            cyc++;
        end
        i_xfer_vld = 1'b0;
        chk({nm, "_seq_done"}, 128'(idx), 128'(seq_q.size()));
        cyc = 0;
        while (o_busy && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk({nm, "_idle"}, 128'(o_busy), 128'(0));
        repeat (3) @(negedge clk);
        #3;
        chk({nm, "_drained"}, 128'(bus_q.size() + rf_q.size()), 128'(0));
        $display("group %s finished", nm);
        seq_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_rf_we,
                              o_rf_waddr, o_rf_wdata, o_stall, o_busy}, 128'(0));
        rst_n = 1'b1;

        // LDMIA r0!,{r1,r2,r3}, ack every cycle
        push_ent(32'd0, 4'd1, 32'h0, 32'h0000_1000);
        push_ent(32'd4, 4'd2, 32'h0, 32'h0000_1004);
        push_ent(32'd8, 4'd3, 32'h0, 32'h0000_1008);
        run_op("ldmia_wb", 32'h0000_1000, 4'd0, 1, 1, 1, 16'h000E, 0, 1, 32'h0000_100C);

        // STMDB sp!,{r4,lr}
        push_ent(32'd4, 4'd14, 32'h1111_EEEE, 32'h0000_1FFC);
        push_ent(32'd8, 4'd4,  32'h4444_0004, 32'h0000_1FF8);
        run_op("stmdb_sp", 32'h0000_2000, 4'd13, 0, 0, 1, 16'h4010, 1, 1, 32'h0000_1FF8);

        // LDMIA r0,{r0,r1} with W=1: no base writeback
        push_ent(32'd0, 4'd0, 32'h0, 32'h0000_3000);
        push_ent(32'd4, 4'd1, 32'h0, 32'h0000_3004);
        run_op("ldm_rn_in_list", 32'h0000_3000, 4'd0, 1, 1, 1, 16'h0003, 0, 0, 32'h0);

        // STMIA r5!,{r2,r7} with 3 wait cycles per beat
        push_ent(32'd0, 4'd2, 32'h2222_A5A5, 32'h0000_4000);
        push_ent(32'd4, 4'd7, 32'h7777_5A5A, 32'h0000_4004);
        run_op("stm_latency3", 32'h0000_4000, 4'd5, 1, 0, 1, 16'h0084, 3, 1, 32'h0000_4008);

        // LDMIB r1!,{r0} from 0xFFFFFFFC wraps to 0
        push_ent(32'd4, 4'd0, 32'h0, 32'h0000_0000);
        run_op("ldmib_wrap", 32'hFFFF_FFFC, 4'd1, 1, 1, 1, 16'h0001, 1, 1, 32'h0000_0000);

        // Empty register list: no bus cycle, no writeback
        run_op("empty_list", 32'h0000_5000, 4'd2, 1, 1, 1, 16'h0000, 0, 0, 32'h0);

        // Reset while a request is outstanding
        lat = 5;
        @(negedge clk); #1;
        i_start = 1'b1; i_base = 32'h0000_6000; i_base_reg = 4'd3;
        i_u = 1'b1; i_l = 1'b1; i_w = 1'b1; i_reglist = 16'h0003;
        @(negedge clk); #1;
        i_start = 1'b0;
        i_xfer_vld = 1'b1; i_xfer_off = 32'd0; i_xfer_reg = 4'd0;
        @(negedge clk); #1;
        i_xfer_vld = 1'b0;
        chk("rst_pre_req", 128'({o_mem_req, o_mem_addr}), 128'({1'b1, 32'h0000_6000}));
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop", 128'({o_mem_req, o_rf_we, o_stall, o_busy}), 128'(0));
        bus_q.delete();
        rf_q.delete();
        exp_beat = rd_cnt;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_release_idle", 128'({o_mem_req, o_rf_we, o_stall, o_busy}), 128'(0));

        // Recovery after reset
        push_ent(32'd0, 4'd9, 32'h0, 32'h0000_7000);
        run_op("post_reset_ldm", 32'h0000_7000, 4'd8, 1, 1, 1, 16'h0200, 0, 1, 32'h0000_7004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
